// File: rtl/div_pkg.sv
// Shared types and constants for the divide sequencer/arbiter.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 4;

    localparam int unsigned REQ0 = 0;
    localparam int unsigned REQ1 = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_core.sv
// Non-restoring divide datapath: A/Q/M registers, shift/add-subtract step and remainder fix.
module div_core
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] a,
    output logic             a_neg
);

    logic [WIDTH:0]   a_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   a_step;

    // One iteration: shift {A,Q} left, then subtract M if A was non-negative, else add it.
    always_comb begin
        m_ext  = {1'b0, m_r};
        a_sh   = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
        a_step = a_r[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
    end

    // Operand capture, iteration and final correction (fix is only strobed when A is negative).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r <= '0;
            q_r <= '0;
            m_r <= '0;
        end else if (load) begin
            a_r <= '0;
            q_r <= dividend;
            m_r <= divisor;
        end else if (step) begin
            a_r <= a_step;
            q_r <= {q_r[WIDTH-2:0], ~a_step[WIDTH]};
        end else if (fix) begin
            a_r <= a_r + m_ext;
        end
    end

    assign q     = q_r;
    assign a     = a_r[WIDTH-1:0];
    assign a_neg = a_r[WIDTH];

endmodule

// File: rtl/div_arbiter.sv
// Round-robin two-port arbiter and sequencer around the iterative divide core.
module div_arbiter
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] dividend0,
    input  logic [WIDTH-1:0] divisor0,
    input  logic [WIDTH-1:0] dividend1,
    input  logic [WIDTH-1:0] divisor1,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       done,
    output logic             dbz,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic             gnt;
    logic             gnt_nxt;
    logic             last;
    logic             zero_div;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;
    logic             load_c;
    logic             step_c;
    logic             fix_c;
    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_a;
    logic             core_a_neg;

    // Operands of the granted requester; only consumed in LOAD.
    assign sel_dividend = gnt ? dividend1 : dividend0;
    assign sel_divisor  = gnt ? divisor1  : divisor0;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, grant selection and core strobes.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        load_c    = 1'b0;
        step_c    = 1'b0;
        fix_c     = 1'b0;
        case (state)
            IDLE: begin
                if (req[REQ0] && req[REQ1]) begin
                    gnt_nxt   = ~last;
                    state_nxt = LOAD;
                end else if (req[REQ1]) begin
                    gnt_nxt   = 1'b1;
                    state_nxt = LOAD;
                end else if (req[REQ0]) begin
                    gnt_nxt   = 1'b0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                load_c    = 1'b1;
                state_nxt = (sel_divisor == '0) ? DONE : ITER;
            end
            ITER: begin
                step_c = 1'b1;
                if (count == CW'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                fix_c     = core_a_neg;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Iteration count, grant, round-robin history and registered results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            gnt       <= 1'b0;
            last      <= 1'b1;
            zero_div  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 2'b00;
            dbz       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt  <= gnt_nxt;
            busy <= (state_nxt != IDLE);
            done <= 2'b00;
            if (state == LOAD) begin
                count    <= CW'(WIDTH);
                zero_div <= (sel_divisor == '0);
            end else if (state == ITER) begin
                count <= count - CW'(1);
            end
            if (state == DONE) begin
                done      <= gnt ? 2'b10 : 2'b01;
                quotient  <= zero_div ? '1 : core_q;
                remainder <= zero_div ? core_q : core_a;
                dbz       <= zero_div;
                last      <= gnt;
            end
        end
    end

    div_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load_c),
        .step    (step_c),
        .fix     (fix_c),
        .dividend(sel_dividend),
        .divisor (sel_divisor),
        .q       (core_q),
        .a       (core_a),
        .a_neg   (core_a_neg)
    );

endmodule
